// File: rtl/cpu_datapath.sv
// Accumulator-machine datapath: 32x8 memory, PC, IR and AC with an 8-bit ALU.
// The controller drives the phase and strobes; this block only executes them.
// A sticky halted flag freezes PC/IR/AC and CPU memory writes until reset.
module cpu_datapath (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       mem_rd,
    input  logic       load_ir,
    input  logic       inc_pc,
    input  logic       load_pc,
    input  logic       load_ac,
    input  logic       mem_wr,
    input  logic       halt,
    input  logic       prog_we,
    input  logic [4:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [2:0] op,
    output logic       zero,
    output logic [4:0] pc,
    output logic [7:0] ac,
    output logic [7:0] ir,
    output logic       halted
);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // No reset on the array: program contents must survive rst.
    logic [7:0] mem [32];
    logic [4:0] addr;
    logic [7:0] data_bus;
    logic [7:0] alu_out;

    assign op   = ir[7:5];
    assign zero = (ac == 8'h00);

    // Fetch phases address by PC, execute phases by the IR operand field.
    assign addr     = state[2] ? ir[4:0] : pc;
    assign data_bus = mem_rd ? mem[addr] : 8'h00;

    // ALU evaluates on the pre-edge IR so load_ir and load_ac can share an edge.
    always_comb begin
        alu_out = ac;
        case (op)
            OP_ADD:  alu_out = ac + data_bus;
            OP_AND:  alu_out = ac & data_bus;
            OP_XOR:  alu_out = ac ^ data_bus;
            OP_LDA:  alu_out = data_bus;
            OP_HLT, OP_SKZ, OP_STO, OP_JMP: alu_out = ac;
            default: alu_out = ac;
        endcase
    end

    // Architectural registers; everything but halted is frozen once halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= 5'd0;
            ir     <= 8'h00;
            ac     <= 8'h00;
            halted <= 1'b0;
        end else begin
            if (halt)
                halted <= 1'b1;
            if (!halted) begin
                if (load_pc)
                    pc <= ir[4:0];
                else if (inc_pc)
                    pc <= pc + 5'd1;
                if (load_ir)
                    ir <= data_bus;
                if (load_ac)
                    ac <= alu_out;
            end
        end
    end

    // Loader writes beat CPU stores; CPU stores are dropped while halted or in reset.
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_addr] <= prog_data;
        else if (mem_wr && !halted && !rst)
            mem[addr] <= ac;
    end

endmodule
